// File: rtl/clk_div_final_core_if.sv
// ---------------------------------------------------------------------------
// clk_div_final_core_if
// Groups the divider's control inputs and its two generated clocks so the
// core and its driver share one bundle.
//   clk_en     : divider enable (0 = hold idle, 1 = run)
//   mode       : speed select (0 = standard quarter, 1 = fast quarter)
//   clk_o_div  : divided clock at 4x the SCL rate, 50% duty
//   SCL        : I2C bus clock, 50% duty, idles high
// The master modport drives the controls; the slave modport is the divider.
// ---------------------------------------------------------------------------
interface clk_div_final_core_if;
  logic clk_en;
  logic mode;
  logic clk_o_div;
  logic SCL;

  modport master (
    output clk_en,
    output mode,
    input  clk_o_div,
    input  SCL
  );

  modport slave (
    input  clk_en,
    input  mode,
    output clk_o_div,
    output SCL
  );
endinterface

// File: rtl/clk_div_final_core.sv
// ---------------------------------------------------------------------------
// clk_div_final_core
// I2C clock generator. A single counter runs over one SCL period of 4*Q
// clk_i cycles, where Q is QTR_STD or QTR_FAST depending on the latched
// mode. SCL is low for the first half of the period and high for the
// second; clk_o_div runs at four times the SCL rate. Both outputs come
// straight from flops.
// Ports:
//   clk_i  : system clock, rising edge
//   rst_n  : asynchronous reset, active HIGH despite its name
//   bus    : slave side of clk_div_final_core_if (clk_en, mode in;
//            clk_o_div, SCL out)
// Parameters:
//   QTR_STD  : clk_o_div period in clk_i cycles for mode 0 (even, >= 2)
//   QTR_FAST : clk_o_div period in clk_i cycles for mode 1 (even, >= 2)
//   CNT_W    : counter width, must hold 4*max(QTR_STD, QTR_FAST)-1
// ---------------------------------------------------------------------------
module clk_div_final_core #(
  parameter int QTR_STD  = 124,
  parameter int QTR_FAST = 30,
  parameter int CNT_W    = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_n,
  clk_div_final_core_if.slave  bus
);

  localparam logic [CNT_W-1:0] QStd  = CNT_W'(QTR_STD);
  localparam logic [CNT_W-1:0] QFast = CNT_W'(QTR_FAST);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mode_q, mode_d;
  logic             scl_q, scl_d;
  logic             div_q, div_d;

  logic [CNT_W-1:0] qtr, halfQtr, twoQtr, threeQtr, lastCnt;
  logic [CNT_W-1:0] phase;

  // Period geometry for the currently latched mode. Q is even so halving
  // by a shift is exact.
  always_comb begin
    qtr      = mode_q ? QFast : QStd;
    halfQtr  = qtr >> 1;
    twoQtr   = qtr << 1;
    threeQtr = twoQtr + qtr;
    lastCnt  = (qtr << 2) - CNT_W'(1);
  end

  // Next-state logic. Disabled is the idle state (SCL high, clk_o_div low,
  // counter parked at zero) and beats a simultaneous wrap. Mode is only
  // picked up while idle or on the wrap edge so a running SCL phase is
  // never cut short. The position inside the current quarter is found by
  // subtracting whole quarters rather than with a divider.
  always_comb begin
    cnt_d  = '0;
    mode_d = bus.mode;
    scl_d  = 1'b1;
    div_d  = 1'b0;
    phase  = '0;
    if (bus.clk_en) begin
      cnt_d = (cnt_q == lastCnt) ? '0 : cnt_q + CNT_W'(1);
      if (cnt_d >= threeQtr)
        phase = cnt_d - threeQtr;
      else if (cnt_d >= twoQtr)
        phase = cnt_d - twoQtr;
      else if (cnt_d >= qtr)
        phase = cnt_d - qtr;
      else
        phase = cnt_d;
      scl_d  = (cnt_d >= twoQtr);
      div_d  = (phase >= halfQtr);
      mode_d = (cnt_d == '0) ? bus.mode : mode_q;
    end
  end

  // State register. Reset forces the bus-idle levels at once, without
  // waiting for a clock edge.
  always_ff @(posedge clk_i or posedge rst_n) begin
    if (rst_n) begin
      cnt_q  <= '0;
      mode_q <= 1'b0;
      scl_q  <= 1'b1;
      div_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      mode_q <= mode_d;
      scl_q  <= scl_d;
      div_q  <= div_d;
    end
  end

  assign bus.SCL       = scl_q;
  assign bus.clk_o_div = div_q;

endmodule

// File: tb/tb_clk_div_final_core.sv
// ---------------------------------------------------------------------------
// tb_clk_div_final_core
// Directed bench for clk_div_final_core. Stimulus pushes the clk_i cycle at
// which every SCL edge and every clk_o_div rising edge must appear; a
// monitor on the falling clock edge pops and compares each edge it sees.
// Edge numbering: cyc is the count of rising clk_i edges; an output that
// changes on edge T is seen by the monitor with cyc == T. A period "base"
// is the edge at which the counter is (or would be) zero, so count k is
// reached at edge base+k.
// ---------------------------------------------------------------------------
module tb_clk_div_final_core;

  localparam int QS = 124;
  localparam int QF = 30;

  typedef struct {
    logic level;
    int   cyc;
  } sclEv_t;

  logic clk_i;
  logic rst_n;
  logic clkRun;
  int   cyc;
  int   vectors;
  int   misses;

  sclEv_t sclExp[$];
  int     divExp[$];
  sclEv_t sclEv;
  int     divEv;
  logic   prevScl;
  logic   prevDiv;

  clk_div_final_core_if bus ();

  clk_div_final_core #(
    .QTR_STD  (QS),
    .QTR_FAST (QF),
    .CNT_W    (16)
  ) dut (
    .clk_i (clk_i),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Clock starts only when the bench asks, so reset can be checked with no
  // edges at all.
  initial begin
    clk_i = 1'b0;
    wait (clkRun);
    forever #5 clk_i = ~clk_i;
  end

  // Rising-edge counter used as the time base for every expectation.
  always @(posedge clk_i) cyc <= cyc + 1;

  // Monitor: every SCL edge and every clk_o_div rising edge must match the
  // head of its queue in both level and cycle.
  always @(negedge clk_i) begin
    if (bus.SCL !== prevScl) begin
      vectors++;
      if (sclExp.size() == 0) begin
        misses++;
        $display("[TB] FAIL sclEdge: got level %0b at cycle %0d, required no edge", bus.SCL, cyc);
      end else begin
        sclEv = sclExp.pop_front();
        if (bus.SCL !== sclEv.level || cyc != sclEv.cyc) begin
          misses++;
          $display("[TB] FAIL sclEdge: got level %0b at cycle %0d, required level %0b at cycle %0d",
                   bus.SCL, cyc, sclEv.level, sclEv.cyc);
        end
      end
      prevScl = bus.SCL;
    end
    if (bus.clk_o_div !== prevDiv) begin
      if (bus.clk_o_div === 1'b1) begin
        vectors++;
        if (divExp.size() == 0) begin
          misses++;
          $display("[TB] FAIL divRise: got rise at cycle %0d, required no rise", cyc);
        end else begin
          divEv = divExp.pop_front();
          if (cyc != divEv) begin
            misses++;
            $display("[TB] FAIL divRise: got rise at cycle %0d, required cycle %0d", cyc, divEv);
          end
        end
      end
      prevDiv = bus.clk_o_div;
    end
  end

  task automatic applyStimulus(input logic en, input logic md);
    bus.clk_en = en;
    bus.mode   = md;
  endtask

  task automatic checkOutput(input string name, input logic expScl, input logic expDiv);
    vectors++;
    if (bus.SCL !== expScl || bus.clk_o_div !== expDiv) begin
      misses++;
      $display("[TB] FAIL %s: SCL/clk_o_div got %0b/%0b, required %0b/%0b",
               name, bus.SCL, bus.clk_o_div, expScl, expDiv);
    end
  endtask

  // Expected edges of one period starting at base, keeping only the events
  // whose count is reached on or before lastCnt (4*q means the wrap).
  task automatic pushPeriod(input int base, input int q, input int lastCnt);
    for (int k = 0; k < 4; k++)
      if (q / 2 + k * q <= lastCnt) divExp.push_back(base + q / 2 + k * q);
    if (2 * q <= lastCnt) sclExp.push_back('{1'b1, base + 2 * q});
    if (4 * q <= lastCnt) sclExp.push_back('{1'b0, base + 4 * q});
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic tickTo(input int target);
    while (cyc < target) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  // Main directed sequence.
  initial begin
    int base, base2, base3, base5, base6, e3, base8, base9;
    vectors = 0;
    misses  = 0;
    cyc     = 0;
    clkRun  = 1'b0;
    prevScl = 1'b1;
    prevDiv = 1'b0;
    rst_n   = 1'b0;
    applyStimulus(1'b0, 1'b0);

    // Reset with no clock at all.
    #1 rst_n = 1'b1;
    #1 checkOutput("rstNoClk", 1'b1, 1'b0);
    clkRun = 1'b1;
    tick(2);
    rst_n = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      checkOutput("idleHold", 1'b1, 1'b0);
    end

    // Standard mode, three periods; the first enabled edge already lands on
    // count 1, so SCL falls on base+1.
    applyStimulus(1'b1, 1'b0);
    base = cyc;
    sclExp.push_back('{1'b0, base + 1});
    pushPeriod(base, QS, 4 * QS);
    pushPeriod(base + 4 * QS, QS, 4 * QS);
    base2 = base + 8 * QS;
    pushPeriod(base2, QS, 4 * QS);
    tick(1);
    checkOutput("firstEdge", 1'b0, 1'b0);
    tickTo(base + 100);
    checkOutput("stdCnt100", 1'b0, 1'b1);

    // Switch to fast at count 100 of the third period; it still runs to 496.
    tickTo(base2 + 100);
    applyStimulus(1'b1, 1'b1);
    base3 = base2 + 4 * QS;
    pushPeriod(base3, QF, 4 * QF);
    pushPeriod(base3 + 4 * QF, QF, 4 * QF);
    base5 = base3 + 8 * QF;
    pushPeriod(base5, QF, 20);
    tickTo(base3 + 50);
    checkOutput("fastCnt50", 1'b0, 1'b1);

    // Drop enable at fast count 20 (SCL low, clk_o_div high).
    tickTo(base5 + 20);
    applyStimulus(1'b0, 1'b1);
    sclExp.push_back('{1'b1, base5 + 21});
    tick(1);
    checkOutput("dropFast", 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);

    // Re-enable in standard mode, drop at count 300, re-enable 20 later.
    tickTo(base5 + 30);
    applyStimulus(1'b1, 1'b0);
    base6 = cyc;
    sclExp.push_back('{1'b0, base6 + 1});
    pushPeriod(base6, QS, 300);
    tick(1);
    checkOutput("enableStd", 1'b0, 1'b0);
    tickTo(base6 + 300);
    applyStimulus(1'b0, 1'b0);
    tick(1);
    checkOutput("dropStd", 1'b1, 1'b0);
    tickTo(base6 + 320);
    applyStimulus(1'b1, 1'b0);
    e3 = cyc;
    sclExp.push_back('{1'b0, e3 + 1});
    pushPeriod(e3, QS, 4 * QS);
    base8 = e3 + 4 * QS;
    pushPeriod(base8, QS, 100);
    tick(1);
    checkOutput("reEnable", 1'b0, 1'b0);

    // 1 ns reset pulse between edges at count 100 of the next period.
    tickTo(base8 + 100);
    sclExp.push_back('{1'b1, base8 + 100});
    sclExp.push_back('{1'b0, base8 + 101});
    base9 = base8 + 100;
    pushPeriod(base9, QS, 4 * QS);
    rst_n = 1'b1;
    #1;
    checkOutput("asyncRst", 1'b1, 1'b0);
    rst_n = 1'b0;
    tick(1);
    checkOutput("postRst", 1'b0, 1'b0);

    tickTo(base9 + 4 * QS + 14);
    vectors++;
    if (sclExp.size() != 0) begin
      misses++;
      $display("[TB] FAIL sclLeftover: got %0d unseen SCL edges, required 0", sclExp.size());
    end
    vectors++;
    if (divExp.size() != 0) begin
      misses++;
      $display("[TB] FAIL divLeftover: got %0d unseen clk_o_div rises, required 0", divExp.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end

endmodule
